// File: rtl/coin_pkg.sv
// Shared coin encodings, coin values and FSM states for the change dispenser.
// COIN_INVENTORY_EN (optional macro) enables the per-coin inventory in users of this package.
package coin_pkg;

  typedef enum logic [1:0] {
    NICKEL  = 2'd0,
    DIME    = 2'd1,
    QUARTER = 2'd2,
    DOLLAR  = 2'd3
  } coin_t;

  localparam int NICKEL_VAL  = 5;
  localparam int DIME_VAL    = 10;
  localparam int QUARTER_VAL = 25;
  localparam int DOLLAR_VAL  = 100;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    GAP,
    DONE
  } state_t;

  function automatic logic [7:0] coinValue(input coin_t c);
    case (c)
      NICKEL:  coinValue = 8'(NICKEL_VAL);
      DIME:    coinValue = 8'(DIME_VAL);
      QUARTER: coinValue = 8'(QUARTER_VAL);
      default: coinValue = 8'(DOLLAR_VAL);
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Four 8-bit coin counters with load/decrement and per-coin nonzero flags.
// Instantiated by change_dispenser only when COIN_INVENTORY_EN is defined.
module coin_inventory
  import coin_pkg::*;
#(
  parameter int INIT_COUNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  coin_t      loadCoin,
  input  logic [7:0] loadCount,
  input  logic       dec,
  input  coin_t      decCoin,
  output logic [3:0] nonZero
);

  for (genvar gi = 0; gi < 4; gi++) begin : gCnt
    logic [7:0] countReg;

    // A load in the same cycle as a decrement of the same coin wins.
    always_ff @(posedge clk) begin
      if (rst) begin
        countReg <= 8'(INIT_COUNT);
      end else if (load && (loadCoin == coin_t'(2'(gi)))) begin
        countReg <= loadCount;
      end else if (dec && (decCoin == coin_t'(2'(gi))) && (countReg != 8'd0)) begin
        countReg <= countReg - 8'd1;
      end
    end

    assign nonZero[gi] = (countReg != 8'd0);
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout sequencer: dollars, quarters, dimes, nickels over valid/ready.
// Optional macro COIN_INVENTORY_EN adds per-coin inventory limits and inv_* load ports.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int VALUE_W    = 11,
  parameter int GAP_CYCLES = 2
`ifdef COIN_INVENTORY_EN
  ,
  parameter int INIT_COUNT = 20
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] change_amt,
  output logic               eject_valid,
  output logic [1:0]         eject_coin,
  input  logic               eject_ready,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [VALUE_W-1:0] remaining
`ifdef COIN_INVENTORY_EN
  ,
  input  logic               inv_load,
  input  logic [1:0]         inv_coin,
  input  logic [7:0]         inv_count
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             stateReg, stateNext;
  logic [VALUE_W-1:0] remainingReg, remainingNext;
  coin_t              coinReg, coinNext;
  logic               errorReg, errorNext;
  logic [GAP_W-1:0]   gapCntReg, gapCntNext;

  logic [3:0] avail;
  logic [3:0] fit;
  coin_t      bestCoin;
  logic       xfer;

  assign xfer = (stateReg == EJECT) && eject_ready;

`ifdef COIN_INVENTORY_EN
  coin_inventory #(
    .INIT_COUNT(INIT_COUNT)
  ) uInv (
    .clk      (clk),
    .rst      (rst),
    .load     (inv_load),
    .loadCoin (coin_t'(inv_coin)),
    .loadCount(inv_count),
    .dec      (xfer),
    .decCoin  (coinReg),
    .nonZero  (avail)
  );
`else
  assign avail = 4'b1111;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : gFit
    assign fit[gi] = avail[gi] &&
                     (remainingReg >= VALUE_W'(coinValue(coin_t'(2'(gi)))));
  end

  always_comb begin
    bestCoin = NICKEL;
    if (fit[3])      bestCoin = DOLLAR;
    else if (fit[2]) bestCoin = QUARTER;
    else if (fit[1]) bestCoin = DIME;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      remainingReg <= '0;
      coinReg      <= NICKEL;
      errorReg     <= 1'b0;
      gapCntReg    <= '0;
    end else begin
      stateReg     <= stateNext;
      remainingReg <= remainingNext;
      coinReg      <= coinNext;
      errorReg     <= errorNext;
      gapCntReg    <= gapCntNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    remainingNext = remainingReg;
    coinNext      = coinReg;
    errorNext     = errorReg;
    gapCntNext    = gapCntReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          remainingNext = change_amt;
          errorNext     = 1'b0;
          stateNext     = SELECT;
        end
      end
      SELECT: begin
        if (|fit) begin
          coinNext  = bestCoin;
          stateNext = EJECT;
        end else begin
          // Error is registered here so it is visible in the same cycle as done.
          errorNext = (remainingReg != '0);
          stateNext = DONE;
        end
      end
      EJECT: begin
        if (eject_ready) begin
          remainingNext = remainingReg - VALUE_W'(coinValue(coinReg));
          gapCntNext    = GAP_W'(GAP_CYCLES - 1);
          stateNext     = GAP;
        end
      end
      GAP: begin
        if (gapCntReg == '0) stateNext = SELECT;
        else                 gapCntNext = gapCntReg - 1'b1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign eject_valid = (stateReg == EJECT);
  assign eject_coin  = coinReg;
  assign busy        = (stateReg != IDLE);
  assign done        = (stateReg == DONE);
  assign error       = errorReg;
  assign remaining   = remainingReg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed-vector bench for change_dispenser; inventory scenario runs when COIN_INVENTORY_EN is defined.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] change_amt;
  logic        eject_valid;
  logic [1:0]  eject_coin;
  logic        eject_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] remaining;
`ifdef COIN_INVENTORY_EN
  logic        inv_load;
  logic [1:0]  inv_coin;
  logic [7:0]  inv_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  int x0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .change_amt (change_amt),
    .eject_valid(eject_valid),
    .eject_coin (eject_coin),
    .eject_ready(eject_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .remaining  (remaining)
`ifdef COIN_INVENTORY_EN
    ,
    .inv_load   (inv_load),
    .inv_coin   (inv_coin),
    .inv_count  (inv_count)
`endif
  );

  always @(posedge clk) begin
    if (eject_valid && eject_ready) xfers <= xfers + 1;
  end

  function automatic int tbVal(input int c);
    case (c)
      0:       return 5;
      1:       return 10;
      2:       return 25;
      default: return 100;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start edge leaves the FSM in SELECT: busy already high, no coin yet.
  task automatic doStart(input int amt);
    start      = 1'b1;
    change_amt = 11'(amt);
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", eject_valid, 0);
    $display("start amount %0d", amt);
  endtask

  // expWait: cycles until eject_valid (1 after start, 2+GAP-1=3 after a transfer).
  task automatic payCoin(input int expCoin, input int expRem, input int expWait);
    int n = 0;
    while (!eject_valid && n < 20) begin
      step();
      n++;
    end
    chk("coin_wait", n, expWait);
    chk("coin_valid", eject_valid, 1);
    chk("coin_type", eject_coin, expCoin);
    chk("coin_rem_before", remaining, expRem);
    step();
    chk("coin_rem_after", remaining, expRem - tbVal(expCoin));
    chk("coin_valid_drop", eject_valid, 0);
    $display("coin %0d paid, remaining %0d -> %0d", expCoin, expRem, expRem - tbVal(expCoin));
  endtask

  task automatic waitDone(input int expWait, input int expErr, input int expRem);
    int n = 0;
    int saw = 0;
    while (!done && n < 20) begin
      step();
      n++;
      if (eject_valid) saw++;
    end
    chk("done_wait", n, expWait);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_error", error, expErr);
    chk("done_rem", remaining, expRem);
    chk("done_no_valid", saw, 0);
    step();
    chk("done_drop", done, 0);
    chk("busy_drop", busy, 0);
    chk("error_held", error, expErr);
    chk("rem_held", remaining, expRem);
    $display("done error %0d remaining %0d", expErr, expRem);
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_valid"}, eject_valid, 0);
    chk({tag, "_coin"}, eject_coin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_rem"}, remaining, 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    change_amt  = '0;
    eject_ready = 1'b1;
`ifdef COIN_INVENTORY_EN
    inv_load  = 1'b0;
    inv_coin  = '0;
    inv_count = '0;
`endif
    step();
    step();
    chkReset("reset");
    rst = 1'b0;
    step();

    // 140 = 100 + 25 + 10 + 5
    doStart(140);
    payCoin(3, 140, 1);
    payCoin(2, 40, 3);
    payCoin(1, 15, 3);
    payCoin(0, 5, 3);
    waitDone(3, 0, 0);

    // Zero amount: SELECT finds nothing, DONE on the second edge after start.
    doStart(0);
    waitDone(1, 0, 0);

    // Non-multiple of 5 leaves a residue and flags error.
    doStart(7);
    payCoin(0, 7, 1);
    waitDone(3, 1, 2);

    // Stalled ejector: coin held stable; a start while busy is ignored.
    eject_ready = 1'b0;
    x0 = xfers;
    doStart(25);
    chk("error_cleared", error, 0);
    step();
    chk("stall_valid0", eject_valid, 1);
    for (int i = 0; i < 10; i++) begin
      start      = (i == 3);
      change_amt = 11'd999;
      step();
      chk("stall_valid", eject_valid, 1);
      chk("stall_coin", eject_coin, 2);
      chk("stall_rem", remaining, 25);
    end
    start = 1'b0;
    $display("stall held 10 cycles");
    eject_ready = 1'b1;
    step();
    chk("stall_rem_after", remaining, 0);
    chk("stall_valid_drop", eject_valid, 0);
    waitDone(3, 0, 0);
    chk("stall_xfers", xfers - x0, 1);

    // Reset while the first dollar waits in EJECT.
    eject_ready = 1'b0;
    x0 = xfers;
    doStart(200);
    step();
    chk("rst_pre_valid", eject_valid, 1);
    chk("rst_pre_coin", eject_coin, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chkReset("midrst");
    chk("midrst_xfers", xfers - x0, 0);
    $display("reset mid-payout");
    eject_ready = 1'b1;
    doStart(5);
    payCoin(0, 5, 1);
    waitDone(3, 0, 0);

`ifdef COIN_INVENTORY_EN
    // No quarters and only three dimes: 50 = 3 x 10 + 4 x 5.
    inv_load  = 1'b1;
    inv_coin  = 2'd2;
    inv_count = 8'd0;
    step();
    inv_coin  = 2'd1;
    inv_count = 8'd3;
    step();
    inv_load = 1'b0;
    doStart(50);
    payCoin(1, 50, 1);
    payCoin(1, 40, 3);
    payCoin(1, 30, 3);
    payCoin(0, 20, 3);
    payCoin(0, 15, 3);
    payCoin(0, 10, 3);
    payCoin(0, 5, 3);
    waitDone(3, 0, 0);
    chk("inv_dime_count", dut.uInv.gCnt[1].countReg, 0);
    chk("inv_quarter_count", dut.uInv.gCnt[2].countReg, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
